// File: rtl/icache_refill_pkg.sv
// Shared instruction-cache constants and refill FSM state encodings.
// Block geometry is derived from the instruction count per block.
package icache_refill_pkg;

    localparam int ICACHE_BLK_INSTR = 4;
    localparam int ICACHE_ADDR_W    = 32;
    localparam int ICACHE_BLK_BYTES = 4 * ICACHE_BLK_INSTR;
    localparam int ICACHE_BLK_W     = 32 * ICACHE_BLK_INSTR;
    localparam int ICACHE_OFF_W     = $clog2(ICACHE_BLK_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_READ     = 2'd2,
        ST_DONE     = 2'd3
    } refill_state_t;

endpackage

// File: rtl/icache_refill.sv
// Refill engine: on a miss, reads one cache block byte-wise from the shared RAM port and strobes it into the cache.
// Latency: miss-to-fill strobe is 3+BLK_BYTES cycles plus any grant wait.
// Backpressure: holds ram_req until granted; flush aborts the refill before DONE, no fill is issued.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int BLK_INSTR = ICACHE_BLK_INSTR,
    parameter int ADDR_W    = ICACHE_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     flush,
    input  logic                     miss,
    input  logic [ADDR_W-1:0]        if_ain,
    output logic                     ram_req,
    input  logic                     ram_gnt,
    output logic [ADDR_W-1:0]        ram_a,
    input  logic [7:0]               ram_din,
    output logic                     mem_in_en,
    output logic [ADDR_W-1:0]        mem_ain,
    output logic [32*BLK_INSTR-1:0]  mem_din
);

    localparam int BLK_BYTES = 4 * BLK_INSTR;
    localparam int BLK_W     = 32 * BLK_INSTR;
    localparam int OFF_W     = $clog2(BLK_BYTES);
    localparam int CNT_W     = OFF_W + 1;

    refill_state_t         state;
    refill_state_t         state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     base;
    logic [BLK_W-1:0]      blk;
    logic                  cnt_last;
    logic                  accept;

    assign cnt_last = (cnt == CNT_W'(BLK_BYTES));
    assign accept   = miss && !flush;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_req   = 1'b0;
        ram_a     = '0;
        mem_in_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                ram_req = 1'b1;
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (ram_gnt) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                ram_req = 1'b1;
                // The final READ cycle only captures the last lane; no new address goes out.
                if (!cnt_last) begin
                    ram_a = base + ADDR_W'(cnt);
                end
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The data is genuine memory content, so a flush here still fills.
                mem_in_en = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            cnt  <= '0;
            base <= '0;
            blk  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        base <= if_ain & ~ADDR_W'(BLK_BYTES - 1);
                        blk  <= '0;
                    end
                end
                ST_WAIT_GNT: begin
                    if (ram_gnt) begin
                        cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (!cnt_last) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // RAM returns data one cycle late, so lane cnt-1 is the one arriving now.
                    for (int i = 0; i < BLK_BYTES; i++) begin
                        if (cnt == CNT_W'(i + 1)) begin
                            blk[8*i +: 8] <= ram_din;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_ain = base;
    assign mem_din = blk;

endmodule

// File: tb/tb_icache_refill.sv
// Randomized scoreboard bench for icache_refill: fills are predicted from a RAM content function
// and cycle arithmetic, and compared by an independent monitor whenever mem_in_en is seen.
module tb_icache_refill;

    localparam int BB = 16;
    localparam int BW = 128;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          flush;
    logic          miss;
    logic [31:0]   if_ain;
    logic          ram_req;
    logic          ram_gnt = 1'b0;
    logic [31:0]   ram_a;
    logic [7:0]    ram_din = 8'h00;
    logic          mem_in_en;
    logic [31:0]   mem_ain;
    logic [BW-1:0] mem_din;

    int errs      = 0;
    int checks    = 0;
    int cyc       = 0;
    int gnt_delay = 0;
    int gnt_wait  = 0;

    typedef struct {
        logic [31:0]   ain;
        logic [BW-1:0] din;
        int            cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] a_q = 32'h0;

    icache_refill dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .flush     (flush),
        .miss      (miss),
        .if_ain    (if_ain),
        .ram_req   (ram_req),
        .ram_gnt   (ram_gnt),
        .ram_a     (ram_a),
        .ram_din   (ram_din),
        .mem_in_en (mem_in_en),
        .mem_ain   (mem_ain),
        .mem_din   (mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory content: page 0x10xx holds its own low address byte, other pages are scrambled.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] x;
        x = (a >> 8) - 32'h10;
        return a[7:0] ^ 8'(x * 32'd59) ^ 8'(x >> 5);
    endfunction

    function automatic logic [BW-1:0] ref_block(input logic [31:0] base);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < BB; i++) r[8*i +: 8] = ram_byte(base + 32'(i));
        return r;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-wide RAM: data for the address seen in a cycle appears just after the following edge.
    always @(negedge clk) a_q = ram_a;
    always @(posedge clk) begin
        #1;
        ram_din = ram_byte(a_q);
    end

    // Arbiter: grants after gnt_delay requesting cycles, holds the grant until ram_req falls.
    always @(negedge clk) begin
        if (ram_req !== 1'b1) begin
            ram_gnt  = 1'b0;
            gnt_wait = 0;
        end else if (gnt_wait >= gnt_delay) begin
            ram_gnt = 1'b1;
        end else begin
            gnt_wait++;
        end
    end

    // Monitor: every fill strobe must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (rst_in === 1'b1 && mem_in_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_fill: mem_ain=%h at cycle %0d, no fill expected", mem_ain, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("fill_addr", BW'(mem_ain), BW'(mon_e.ain));
                check("fill_data", mem_din, mon_e.din);
                check("fill_cycle", BW'(cyc), BW'(mon_e.cyc));
            end
        end
    end

    task automatic expect_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL %s: %0d fills still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // One miss at addr with grant delay d; flush pulsed in cycle f (f<0: never). Cycle 0 = miss cycle.
    task automatic run_case(input logic [31:0] addr, input int d, input int f);
        logic [31:0] base;
        logic [31:0] exp_a;
        bit          accepted;
        bit          survive;
        bit          exp_req;
        int          p;
        base     = addr & ~32'(BB - 1);
        accepted = (f != 0);
        survive  = accepted && !(f >= 1 && f <= 2 + BB + d);
        gnt_delay = d;
        @(posedge clk); #1;
        miss   = 1'b1;
        if_ain = addr;
        flush  = (f == 0);
        p      = cyc;
        if (survive) sb.push_back('{base, ref_block(base), p + 3 + BB + d});
        for (int c = 0; c <= 5 + BB + d; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                miss  = 1'b0;
                flush = (c == f);
            end
            exp_req = accepted && !(f >= 1 && f < c) && c >= 1 && c <= 2 + BB + d;
            exp_a   = (exp_req && c >= 2 + d && c <= 1 + BB + d) ? base + 32'(c - 2 - d) : 32'h0;
            @(negedge clk);
            check("ram_req", BW'(ram_req), BW'(exp_req));
            check("ram_a", BW'(ram_a), BW'(exp_a));
        end
        flush = 1'b0;
        expect_drained("fill_missing");
    endtask

    task automatic back_to_back();
        int p;
        gnt_delay = 0;
        @(posedge clk); #1;
        miss   = 1'b1;
        if_ain = 32'h0000_3000;
        p      = cyc;
        sb.push_back('{32'h0000_3000, ref_block(32'h0000_3000), p + 3 + BB});
        sb.push_back('{32'h0000_3010, ref_block(32'h0000_3010), p + 2 * (3 + BB) + 1});
        @(posedge clk); #1;
        if_ain = 32'h0000_3010;
        repeat (20) @(posedge clk);
        #1;
        miss = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        expect_drained("b2b_missing");
    endtask

    task automatic reset_mid_read();
        gnt_delay = 0;
        @(posedge clk); #1;
        miss   = 1'b1;
        if_ain = 32'h5555_0123;
        @(posedge clk); #1;
        miss = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_in = 1'b0;
        #1;
        check("arst_ram_req", BW'(ram_req), BW'(1'b0));
        check("arst_mem_in_en", BW'(mem_in_en), BW'(1'b0));
        check("arst_mem_din", mem_din, '0);
        check("arst_ram_a", BW'(ram_a), BW'(32'h0));
        check("arst_mem_ain", BW'(mem_ain), BW'(32'h0));
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1;
        run_case(32'h5555_0123, 1, -1);
    endtask

    initial begin
        int d;
        int f;
        rst_in = 1'b0;
        flush  = 1'b0;
        miss   = 1'b0;
        if_ain = 32'h0;
        #12;
        check("rst_ram_req", BW'(ram_req), BW'(1'b0));
        check("rst_ram_a", BW'(ram_a), BW'(32'h0));
        check("rst_mem_in_en", BW'(mem_in_en), BW'(1'b0));
        check("rst_mem_ain", BW'(mem_ain), BW'(32'h0));
        check("rst_mem_din", mem_din, '0);
        @(negedge clk);
        rst_in = 1'b1;

        run_case(32'h0000_1008, 0, -1);      // basic refill, fill in cycle 19
        run_case(32'h0000_1008, 5, -1);      // delayed grant, fill in cycle 24
        run_case(32'h0000_1008, 0, 9);       // flush while cnt=7
        run_case(32'h0000_2004, 0, -1);
        run_case(32'h0000_1008, 2, 3 + BB + 2); // flush during DONE
        run_case(32'h0000_1008, 0, 0);       // flush with miss in IDLE
        back_to_back();
        reset_mid_read();
        run_case(32'hFFFF_FFF7, 0, -1);      // top-of-memory block

        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 6));
            f = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 5 + BB + d));
            run_case($urandom, d, f);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
